// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - flywheel lock and mismatch counter for a programmable-tap LFSR word stream
// Define LFSR_CHK_BIDIR_EN to also lock onto reverse-stepping streams.
module lfsr_checker #(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tapData,
  input  logic             tapEn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state,
  output logic             dir
);

  typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} st_t;

  localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);
  localparam logic [3:0]       LOSS_C  = 4'(LOSS_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  st_t              st;
  logic [WIDTH-1:0] taps;
  logic [WIDTH-1:0] ref_q;
  logic [3:0]       match_q;
  logic [3:0]       miss_q;
  logic             dir_q;

  function automatic logic [WIDTH-1:0] step_fwd(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] t);
    return {x[WIDTH-2:0], ^(x & t)};
  endfunction

  logic [WIDTH-1:0] ref_next;
  logic [WIDTH-1:0] ref_lock;
  logic             y_nz;
  logic             fwd_hit;
  logic             sync_hit;
  logic             sync_dir;
  logic [3:0]       sync_cnt;
  logic             lock_hit;
  logic             err_hit;

  assign ref_next = step_fwd(ref_q, taps);
  assign y_nz     = |in_data;
  assign fwd_hit  = y_nz && (in_data == ref_next);

`ifdef LFSR_CHK_BIDIR_EN
  function automatic logic [WIDTH-1:0] step_rev(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] t);
    return {x[0] ^ (^(x[WIDTH-1:1] & t[WIDTH-2:0])), x[WIDTH-1:1]};
  endfunction

  logic y_pred;
  logic rev_hit;
  logic same_dir;

  assign y_pred   = (step_fwd(in_data, taps) == ref_q);
  assign rev_hit  = y_nz && y_pred;
  assign same_dir = (match_q != 4'd0) && (dir_q ? rev_hit : fwd_hit);
  assign sync_hit = fwd_hit || rev_hit;
  assign sync_dir = same_dir ? dir_q : !fwd_hit;
  assign sync_cnt = same_dir ? match_q + 4'd1 : 4'd1;
  assign lock_hit = dir_q ? y_pred : (in_data == ref_next);
  // Without the top tap the predecessor is ambiguous, so the observed word becomes the reference.
  assign ref_lock = !dir_q ? ref_next :
                    (taps[WIDTH-1] ? step_rev(ref_q, taps) : in_data);
`else
  assign sync_hit = fwd_hit;
  assign sync_dir = 1'b0;
  assign sync_cnt = match_q + 4'd1;
  assign lock_hit = (in_data == ref_next);
  assign ref_lock = ref_next;
`endif

  assign err_hit = in_valid && !tapEn && (st == LOCKED) && !lock_hit;
  assign state   = st;
  assign dir     = dir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps      <= '0;
      st        <= HUNT;
      ref_q     <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
      dir_q     <= 1'b0;
    end else begin
      err <= err_hit;
      if (clr_cnt)
        err_count <= '0;
      else if (err_hit && (err_count != CNT_MAX))
        err_count <= err_count + CNT_ONE;

      if (tapEn) begin
        taps    <= tapData;
        st      <= HUNT;
        ref_q   <= '0;
        match_q <= '0;
        miss_q  <= '0;
        locked  <= 1'b0;
        dir_q   <= 1'b0;
      end else if (in_valid) begin
        case (st)
          HUNT: begin
            if (y_nz) begin
              ref_q   <= in_data;
              st      <= SYNC;
              match_q <= '0;
            end
          end
          SYNC: begin
            if (sync_hit) begin
              ref_q   <= in_data;
              match_q <= sync_cnt;
              dir_q   <= sync_dir;
              if (sync_cnt == LOCK_C) begin
                st     <= LOCKED;
                locked <= 1'b1;
                miss_q <= '0;
              end
            end else begin
              match_q <= '0;
              if (y_nz)
                ref_q <= in_data;
              else
                st <= HUNT;
            end
          end
          LOCKED: begin
            // Flywheel: the reference advances regardless of what was observed.
            ref_q <= ref_lock;
            if (lock_hit) begin
              miss_q <= '0;
            end else if (miss_q + 4'd1 == LOSS_C) begin
              st      <= HUNT;
              locked  <= 1'b0;
              match_q <= '0;
              miss_q  <= '0;
            end else begin
              miss_q <= miss_q + 4'd1;
            end
          end
          default: begin
            st     <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - scoreboard bench for lfsr_checker
// Covers LFSR_CHK_BIDIR_EN builds as well as the default forward-only build.
module tb_lfsr_checker;

  logic        clk;
  logic        rst_n;
  logic [7:0]  tapData;
  logic        tapEn;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        clr_cnt;
  logic        locked;
  logic        err;
  logic [15:0] err_count;
  logic [1:0]  state;
  logic        dir;

  lfsr_checker #(.WIDTH(8), .LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tapData  (tapData),
    .tapEn    (tapEn),
    .in_valid (in_valid),
    .in_data  (in_data),
    .clr_cnt  (clr_cnt),
    .locked   (locked),
    .err      (err),
    .err_count(err_count),
    .state    (state),
    .dir      (dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       nm;
    logic        lk;
    logic [1:0]  st;
    logic        e;
    logic [15:0] cnt;
    logic        d;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: outputs are settled 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t x;
    #1;
    cyc++;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      x = exp_q.pop_front();
      n_tests++;
      if (x.cyc != cyc || locked !== x.lk || state !== x.st || err !== x.e ||
          err_count !== x.cnt || dir !== x.d) begin
        n_fail++;
        $display("FAIL %s: got locked=%0b state=%0d err=%0b cnt=%0d dir=%0b, expected locked=%0b state=%0d err=%0b cnt=%0d dir=%0b",
                 x.nm, locked, state, err, err_count, dir, x.lk, x.st, x.e, x.cnt, x.d);
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic te,
                       input logic [7:0] td, input logic clr, input string nm,
                       input logic lk, input logic [1:0] s, input logic e,
                       input logic [15:0] c, input logic dr);
    exp_t x;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    tapEn    = te;
    tapData  = td;
    clr_cnt  = clr;
    x.cyc = cyc + 1;
    x.nm  = nm;
    x.lk  = lk;
    x.st  = s;
    x.e   = e;
    x.cnt = c;
    x.d   = dr;
    exp_q.push_back(x);
  endtask

  task automatic feed(input logic [7:0] d, input string nm, input logic lk,
                      input logic [1:0] s, input logic e, input logic [15:0] c);
    drive(1'b1, d, 1'b0, 8'h00, 1'b0, nm, lk, s, e, c, 1'b0);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; tapData = 8'h00; tapEn = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; clr_cnt = 1'b0;
    #12;
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_err",    32'(err), 32'd0);
    check("reset_cnt",    32'(err_count), 32'd0);
    check("reset_state",  32'(state), 32'd0);
    check("reset_dir",    32'(dir), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lock with taps 0x5c
    drive(1'b0, 8'h00, 1'b1, 8'h5c, 1'b0, "load_5c", 0, 0, 0, 0, 0);
    feed(8'hff, "t1_ff", 0, 1, 0, 0);
    feed(8'hfe, "t1_fe", 0, 1, 0, 0);
    feed(8'hfc, "t1_fc", 0, 1, 0, 0);
    feed(8'hf8, "t1_f8", 0, 1, 0, 0);
    feed(8'hf1, "t1_lock", 1, 2, 0, 0);

    // Single error then flywheel recovery
    feed(8'he2, "t2_e2", 1, 2, 0, 0);
    feed(8'h00, "t2_err", 1, 2, 1, 1);
    feed(8'h8a, "t2_8a", 1, 2, 0, 1);

    // Three consecutive bad words drop lock; a zero word is ignored in HUNT
    feed(8'h33, "t3_bad1", 1, 2, 1, 2);
    feed(8'h33, "t3_bad2", 1, 2, 1, 3);
    feed(8'h33, "t3_loss", 0, 0, 1, 4);
    feed(8'h00, "t3_zero", 0, 0, 0, 4);

    // Relock, then tap reload (with a dropped word) keeps err_count; clr clears it
    feed(8'hff, "t4_ff", 0, 1, 0, 4);
    feed(8'hfe, "t4_fe", 0, 1, 0, 4);
    feed(8'hfc, "t4_fc", 0, 1, 0, 4);
    feed(8'hf8, "t4_f8", 0, 1, 0, 4);
    feed(8'hf1, "t4_lock", 1, 2, 0, 4);
    drive(1'b1, 8'he2, 1'b1, 8'h9c, 1'b0, "t4_tapen", 0, 0, 0, 4, 0);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, "t4_clr", 0, 0, 0, 0, 0);

    // Relock, idle cycles, error coinciding with clear
    drive(1'b0, 8'h00, 1'b1, 8'h5c, 1'b0, "t5_load", 0, 0, 0, 0, 0);
    feed(8'hff, "t5_ff", 0, 1, 0, 0);
    feed(8'hfe, "t5_fe", 0, 1, 0, 0);
    feed(8'hfc, "t5_fc", 0, 1, 0, 0);
    feed(8'hf8, "t5_f8", 0, 1, 0, 0);
    feed(8'hf1, "t5_lock", 1, 2, 0, 0);
    for (int i = 0; i < 10; i++)
      drive(1'b0, 8'h55, 1'b0, 8'h00, 1'b0, "t5_idle", 1, 2, 0, 0, 0);
    drive(1'b1, 8'h55, 1'b0, 8'h00, 1'b1, "t5_err_clr", 1, 2, 1, 0, 0);
    feed(8'hc5, "t5_c5", 1, 2, 0, 0);
    feed(8'h55, "t5_err", 1, 2, 1, 1);

    // Asynchronous reset mid-stream
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h15;
    #2 rst_n = 1'b0;
    #1;
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_err",    32'(err), 32'd0);
    check("arst_cnt",    32'(err_count), 32'd0);
    check("arst_state",  32'(state), 32'd0);
    check("arst_dir",    32'(dir), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Taps are back to zero: plain shift sequence locks
    feed(8'hff, "t0_ff", 0, 1, 0, 0);
    feed(8'hfe, "t0_fe", 0, 1, 0, 0);
    feed(8'hfc, "t0_fc", 0, 1, 0, 0);
    feed(8'hf8, "t0_f8", 0, 1, 0, 0);
    feed(8'hf0, "t0_lock", 1, 2, 0, 0);

    // Reverse-stepping stream
    drive(1'b0, 8'h00, 1'b1, 8'h5c, 1'b0, "t6_load", 0, 0, 0, 0, 0);
`ifdef LFSR_CHK_BIDIR_EN
    drive(1'b1, 8'hc5, 1'b0, 8'h00, 1'b0, "t6_c5", 0, 1, 0, 0, 0);
    drive(1'b1, 8'he2, 1'b0, 8'h00, 1'b0, "t6_e2", 0, 1, 0, 0, 1);
    drive(1'b1, 8'hf1, 1'b0, 8'h00, 1'b0, "t6_f1", 0, 1, 0, 0, 1);
    drive(1'b1, 8'hf8, 1'b0, 8'h00, 1'b0, "t6_f8", 0, 1, 0, 0, 1);
    drive(1'b1, 8'hfc, 1'b0, 8'h00, 1'b0, "t6_lock", 1, 2, 0, 0, 1);
    drive(1'b1, 8'hfe, 1'b0, 8'h00, 1'b0, "t6_fe", 1, 2, 0, 0, 1);
    drive(1'b1, 8'h13, 1'b0, 8'h00, 1'b0, "t6_err", 1, 2, 1, 1, 1);
`else
    feed(8'hc5, "t6_c5", 0, 1, 0, 0);
    feed(8'he2, "t6_e2", 0, 1, 0, 0);
    feed(8'hf1, "t6_f1", 0, 1, 0, 0);
    feed(8'hf8, "t6_f8", 0, 1, 0, 0);
    feed(8'hfc, "t6_nolock", 0, 1, 0, 0);
    feed(8'hfe, "t6_fe", 0, 1, 0, 0);
    feed(8'h13, "t6_13", 0, 1, 0, 0);
`endif

    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
